macc_acc_round: RTL and testbench

- Downstream consumer of the 48-bit MACC result stream (p = a*b + carryin).
- Accumulates a frame of signed MACC results, delimited by in_last.
- At end of frame, rounds, shifts and saturates the sum to OUT_W bits.
- Presents the result on a ready/valid output with full backpressure.
- Sits between the DSP MACC slice and the narrow result bus.

---
 rtl/macc_pkg.sv | 14 +
 rtl/macc_round_sat.sv | 42 ++++
 rtl/macc_acc_round.sv | 131 +++++++++++++
 tb/tb_macc_acc_round.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared state encoding and default widths for the MACC frame accumulator.
package macc_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      ROUND = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int MACC_IN_W  = 48;
   localparam int MACC_ACC_W = 56;
   localparam int MACC_OUT_W = 24;

endpackage

// File: rtl/macc_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation
// of the frame accumulator down to the output width.
module macc_round_sat
   import macc_pkg::*;
#(
   parameter int ACC_W = MACC_ACC_W,
   parameter int SHIFT = 8,
   parameter int OUT_W = MACC_OUT_W
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] value,
   output logic                    sat
);

   // One guard bit so adding the rounding constant cannot wrap.
   localparam int RW = ACC_W + 1;

   logic signed [RW-1:0] half;
   logic signed [RW-1:0] biased;
   logic signed [RW-1:0] r;
   logic signed [RW-1:0] max_w;
   logic signed [RW-1:0] min_w;

   assign half   = RW'(1) << (SHIFT - 1);
   assign biased = {acc[ACC_W-1], acc} + half;
   assign r      = biased >>> SHIFT;
   assign max_w  = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   assign min_w  = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      value = r[OUT_W-1:0];
      sat   = 1'b0;
      if (r > max_w) begin
         value = {1'b0, {(OUT_W-1){1'b1}}};
         sat   = 1'b1;
      end else if (r < min_w) begin
         value = {1'b1, {(OUT_W-1){1'b0}}};
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/macc_acc_round.sv
// Frame accumulator for the MACC result stream: sums a frame, then rounds,
// shifts and saturates it onto a ready/valid output. MACC_ACC_OVF_SAT_EN adds
// sticky accumulator overflow clamping.
//
// state | meaning
// ACCUM | accepting samples, summing into acc
// ROUND | one cycle: round/saturate acc into the output registers, clear acc
// HOLD  | result presented, waiting for out_ready
module macc_acc_round
   import macc_pkg::*;
#(
   parameter int IN_W  = MACC_IN_W,
   parameter int ACC_W = MACC_ACC_W,
   parameter int SHIFT = 8,
   parameter int OUT_W = MACC_OUT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat
);

   state_t state_q, state_d;

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [OUT_W-1:0] rs_value;
   logic signed [OUT_W-1:0] sat_max;
   logic signed [OUT_W-1:0] sat_min;
   logic                    rs_sat;
   logic                    in_xfer;
   logic                    ovf_q;
   logic                    ovf_neg_q;

   assign in_ready = (state_q == ACCUM);
   assign in_xfer  = in_valid && in_ready;
   assign in_ext   = ACC_W'(in_data);
   assign acc_sum  = acc_q + in_ext;
   assign sat_max  = {1'b0, {(OUT_W-1){1'b1}}};
   assign sat_min  = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef MACC_ACC_OVF_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic add_ovf;

   assign add_ovf  = (acc_q[ACC_W-1] == in_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
   assign acc_next = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : acc_sum;

   // Direction of the most recent overflow picks the saturated output sign.
   always_ff @(posedge clk) begin
      if (rst || state_q == ROUND) begin
         ovf_q     <= 1'b0;
         ovf_neg_q <= 1'b0;
      end else if (in_xfer && add_ovf) begin
         ovf_q     <= 1'b1;
         ovf_neg_q <= acc_q[ACC_W-1];
      end
   end
`else
   assign acc_next  = acc_sum;
   assign ovf_q     = 1'b0;
   assign ovf_neg_q = 1'b0;
`endif

   macc_round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .acc   (acc_q),
      .value (rs_value),
      .sat   (rs_sat)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (in_xfer && in_last) state_d = ROUND;
         ROUND:   state_d = HOLD;
         HOLD:    if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_xfer) acc_q <= acc_next;
            end
            ROUND: begin
               acc_q     <= '0;
               out_valid <= 1'b1;
               if (ovf_q) begin
                  out_data <= ovf_neg_q ? sat_min : sat_max;
                  out_sat  <= 1'b1;
               end else begin
                  out_data <= rs_value;
                  out_sat  <= rs_sat;
               end
            end
            HOLD: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_macc_acc_round.sv
// Directed plus randomised frames against macc_acc_round with an expected-result
// queue filled as frames are driven and drained as results are handshaken.
module tb_macc_acc_round;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [47:0] in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic signed [23:0] out_data;
   logic               out_sat;

   typedef struct packed {
      logic [23:0] data;
      logic        sat;
   } exp_t;

   exp_t sb[$];
   int   vec  = 0;
   int   miss = 0;

   always #5 clk = ~clk;

   macc_acc_round dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input longint s);
      longint r;
      exp_t   e;
      r = (s + 64'sd128) >>> 8;
      if (r > 64'sd8388607) begin
         e.data = 24'h7fffff; e.sat = 1'b1;
      end else if (r < -64'sd8388608) begin
         e.data = 24'h800000; e.sat = 1'b1;
      end else begin
         e.data = r[23:0];    e.sat = 1'b0;
      end
      return e;
   endfunction

   task automatic push(input logic [23:0] d, input logic s);
      exp_t e;
      e.data = d;
      e.sat  = s;
      sb.push_back(e);
   endtask

   task automatic send(input logic signed [47:0] d, input logic last);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      chk("in_ready_accum", {47'h0, in_ready}, 48'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input int stall);
      int          n;
      exp_t        e;
      logic [23:0] d0;
      logic        s0;
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 48'(n), 48'd2);
      if (!out_valid) return;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 48'h0, 48'h1);
         return;
      end
      e  = sb.pop_front();
      d0 = out_data;
      s0 = out_sat;
      chk("out_data", {24'h0, out_data}, {24'h0, e.data});
      chk("out_sat", {47'h0, out_sat}, {47'h0, e.sat});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("hold_valid", {47'h0, out_valid}, 48'h1);
         chk("hold_data", {24'h0, out_data}, {24'h0, d0});
         chk("hold_sat", {47'h0, out_sat}, {47'h0, s0});
         chk("hold_in_ready", {47'h0, in_ready}, 48'h0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_after_hs", {47'h0, out_valid}, 48'h0);
      chk("in_ready_after_hs", {47'h0, in_ready}, 48'h1);
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", {47'h0, out_valid}, 48'h0);
      chk("rst_out_data", {24'h0, out_data}, 48'h0);
      chk("rst_out_sat", {47'h0, out_sat}, 48'h0);
      chk("rst_in_ready", {47'h0, in_ready}, 48'h1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state();

      // single-sample frame
      push(24'd3, 1'b0);
      send(48'sd837, 1'b1);
      get_result(0);

      // two-sample frame
      push(24'd5, 1'b0);
      send(48'sd837, 1'b0);
      send(48'sd396, 1'b1);
      get_result(0);

      // negative rounding around the half point
      push(24'hffffff, 1'b0);
      send(-48'sd384, 1'b1);
      get_result(0);
      push(24'hfffffe, 1'b0);
      send(-48'sd385, 1'b1);
      get_result(0);

      // saturation both ways
      push(24'h7fffff, 1'b1);
      send(48'sd1 <<< 40, 1'b1);
      get_result(0);
      push(24'h800000, 1'b1);
      send(-(48'sd1 <<< 40), 1'b1);
      get_result(0);

      // backpressure, then next sample taken right after the handshake
      push(24'd4, 1'b0);
      send(48'sd1000, 1'b1);
      get_result(5);
      send(48'sd837, 1'b0);

      // reset mid-frame discards the partial 837
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state();
      push(24'd2, 1'b0);
      send(48'sd396, 1'b1);
      get_result(0);

      // reset while holding a result drops it
      send(48'sd1 <<< 40, 1'b1);
      repeat (2) @(negedge clk);
      chk("hold_before_rst", {47'h0, out_valid}, 48'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state();

      // randomised frames through the reference model
      for (int f = 0; f < 6; f++) begin
         int     ns;
         longint sum;
         ns  = int'($urandom_range(1, 4));
         sum = 0;
         for (int k = 0; k < ns; k++) begin
            longint v;
            v   = longint'($signed($urandom()));
            v   = v <<< $urandom_range(0, 8);
            sum = sum + v;
            if (k == ns - 1) sb.push_back(model(sum));
            send(v[47:0], (k == ns - 1));
         end
         get_result(int'($urandom_range(0, 2)));
      end

      chk("scoreboard_drained", 48'(sb.size()), 48'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
